// File: rtl/noc_types.sv
// Shared NoC types and constants for the buffered virtual-channel link.
// The optional statistics block in noc_vc_link is enabled by NOC_LINK_STATS_EN.
package noc_types;

    localparam int NUM_VC_MAX   = 8;
    localparam int LINK_LATENCY = 2;

    typedef logic [$clog2(NUM_VC_MAX)-1:0] vc_id_t;

    // Round-robin successor of a VC index among n channels.
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-VC synchronous FIFO with occupancy count; push is ignored when full,
// pop is ignored when empty. Storage is not reset, only pointers and count.
module noc_vc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_vc_link.sv
// Buffered NUM_VC virtual-channel link: per-VC FIFOs, round-robin arbiter and a
// registered valid/ready output stage. NOC_LINK_STATS_EN adds handshake/stall counters.
module noc_vc_link
    import noc_types::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int NUM_VC     = 2,
    parameter int DEPTH      = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_VC-1:0]                         in_valid,
    output logic [NUM_VC-1:0]                         in_ready,
    input  logic [NUM_VC*FLIT_WIDTH-1:0]              in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [(NUM_VC > 1 ? $clog2(NUM_VC) : 1)-1:0] out_vc,
`ifdef NOC_LINK_STATS_EN
    output logic [NUM_VC*32-1:0]                      stat_flits,
    output logic [31:0]                               stat_stall,
`endif
    output logic [FLIT_WIDTH-1:0]                     out_data
);

    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic [NUM_VC-1:0]     full;
    logic [NUM_VC-1:0]     empty;
    logic [NUM_VC-1:0]     pop;
    logic [FLIT_WIDTH-1:0] head [NUM_VC];
    logic [VC_W-1:0]       prio;
    logic [VC_W-1:0]       gnt;
    int                    grant;
    logic                  found;
    logic                  load;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        noc_vc_fifo #(
            .WIDTH (FLIT_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (in_valid[v]),
            .push_data (in_data[v*FLIT_WIDTH +: FLIT_WIDTH]),
            .pop       (pop[v]),
            .head      (head[v]),
            .full      (full[v]),
            .empty     (empty[v])
        );
    end

    // Readiness depends only on registered FIFO occupancy.
    assign in_ready = ~full;

    // Rotating priority: first non-empty VC at or above prio, then wrap to the bottom.
    always_comb begin
        grant = 0;
        found = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (!found && !empty[v] && (v >= int'(prio))) begin
                grant = v;
                found = 1'b1;
            end
        end
        for (int v = 0; v < NUM_VC; v++) begin
            if (!found && !empty[v]) begin
                grant = v;
                found = 1'b1;
            end
        end
    end

    assign gnt  = VC_W'(grant);
    assign load = (!out_valid || out_ready) && found;

    always_comb begin
        pop = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            pop[v] = load && (grant == v);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_vc    <= '0;
            out_data  <= '0;
            prio      <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_vc    <= gnt;
            out_data  <= head[gnt];
            prio      <= VC_W'(rr_next(grant, NUM_VC));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef NOC_LINK_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    for (genvar v = 0; v < NUM_VC; v++) begin : g_stat
        logic [31:0] flits;
        always_ff @(posedge clk) begin
            if (rst) begin
                flits <= '0;
            end else if (out_valid && out_ready && (out_vc == VC_W'(v))) begin
                flits <= sat_inc(flits);
            end
        end
        assign stat_flits[v*32 +: 32] = flits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall <= '0;
        end else if (out_valid && !out_ready) begin
            stat_stall <= sat_inc(stat_stall);
        end
    end
`endif

endmodule

// File: tb/tb_noc_vc_link.sv
// Randomised and directed bench for noc_vc_link against a queue-based reference model.
// Statistics ports are exercised when NOC_LINK_STATS_EN is defined.
module tb_noc_vc_link;

    localparam int FW = 32;
    localparam int NV = 2;
    localparam int D  = 4;

    logic              clk;
    logic              rst;
    logic [NV-1:0]     in_valid;
    logic [NV-1:0]     in_ready;
    logic [NV*FW-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [0:0]        out_vc;
    logic [FW-1:0]     out_data;
`ifdef NOC_LINK_STATS_EN
    logic [NV*32-1:0]  stat_flits;
    logic [31:0]       stat_stall;
    int                m_flits [NV];
    int                m_stall;
`endif

    noc_vc_link #(
        .FLIT_WIDTH (FW),
        .NUM_VC     (NV),
        .DEPTH      (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vc     (out_vc),
`ifdef NOC_LINK_STATS_EN
        .stat_flits (stat_flits),
        .stat_stall (stat_stall),
`endif
        .out_data   (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-VC queues, one output slot, rotating priority.
    logic [FW-1:0] mq [NV][$];
    bit            m_ov;
    int            m_vc;
    logic [FW-1:0] m_od;
    int            m_prio;

    logic [FW-1:0] got_d [$];
    int            got_v [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [NV-1:0] iv, input logic [NV*FW-1:0] id,
                        input logic ordy, input logic r);
        bit acc [NV];
        int g;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        rst       = r;
        if (!r && out_valid === 1'b1 && ordy) begin
            got_d.push_back(out_data);
            got_v.push_back(int'(out_vc));
        end
        for (int v = 0; v < NV; v++) acc[v] = iv[v] && (mq[v].size() < D);
        @(posedge clk);
        if (r) begin
            for (int v = 0; v < NV; v++) mq[v].delete();
            m_ov = 0; m_vc = 0; m_od = '0; m_prio = 0;
`ifdef NOC_LINK_STATS_EN
            for (int v = 0; v < NV; v++) m_flits[v] = 0;
            m_stall = 0;
`endif
        end else begin
`ifdef NOC_LINK_STATS_EN
            if (m_ov && ordy) m_flits[m_vc]++;
            if (m_ov && !ordy) m_stall++;
`endif
            g = -1;
            for (int k = 0; k < NV; k++) begin
                int c;
                c = (m_prio + k) % NV;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
            if ((!m_ov || ordy) && g >= 0) begin
                m_ov   = 1;
                m_vc   = g;
                m_od   = mq[g].pop_front();
                m_prio = (g + 1) % NV;
            end else if (ordy) begin
                m_ov = 0;
            end
            for (int v = 0; v < NV; v++)
                if (acc[v]) mq[v].push_back(id[v*FW +: FW]);
        end
        @(negedge clk);
        for (int v = 0; v < NV; v++)
            check($sformatf("in_ready%0d", v), in_ready[v], mq[v].size() < D);
        check("out_valid", out_valid, m_ov);
        check("out_vc", out_vc, m_vc);
        check("out_data", out_data, m_od);
`ifdef NOC_LINK_STATS_EN
        for (int v = 0; v < NV; v++)
            check($sformatf("stat_flits%0d", v), stat_flits[v*32 +: 32], m_flits[v]);
        check("stat_stall", stat_stall, m_stall);
`endif
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step('0, '0, ordy, 1'b0);
    endtask

    initial begin
        in_valid = '0; in_data = '0; out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        step('0, '0, 1'b1, 1'b1);
        check("rst_in_ready", in_ready, 2'b11);
        check("rst_out_valid", out_valid, 1'b0);

        // Single flit: two-cycle latency.
        step(2'b01, {32'h0, 32'hA5}, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        check("t1_valid", out_valid, 1'b1);
        check("t1_vc", out_vc, 1'b0);
        check("t1_data", out_data, 32'hA5);
        idle(3, 1'b1);

        // Hold the output with a VC0 flit, then fill VC1 under backpressure.
        step(2'b01, {32'h0, 32'h77}, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(2'b10, {32'h10 + 32'(i), 32'h0}, 1'b0, 1'b0);
        check("t2_full", in_ready[1], 1'b0);
        step(2'b10, {32'h14, 32'h0}, 1'b0, 1'b0);
        got_d.delete(); got_v.delete();
        idle(7, 1'b1);
        check("t2_count", got_d.size(), 5);
        if (got_d.size() == 5) begin
            check("t2_d0", got_d[0], 32'h77);
            for (int i = 1; i < 5; i++) check("t2_order", got_d[i], 32'h10 + 32'(i - 1));
        end

        // Two rounds of balanced traffic: strict alternation, first grant VC0.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 3; i++)
                step(2'b11, {32'h30 + 32'(i), 32'h20 + 32'(i)}, 1'b0, 1'b0);
            got_d.delete(); got_v.delete();
            idle(6, 1'b1);
            check("t3_count", got_v.size(), 6);
            if (got_v.size() == 6) begin
                check("t3_first", got_v[0], 0);
                for (int i = 1; i < 6; i++) check("t3_alt", got_v[i] != got_v[i-1], 1'b1);
            end
            idle(2, 1'b1);
        end

        // Backpressure hold, then reset with flits in flight.
        for (int i = 0; i < 3; i++) step(2'b01, {32'h0, 32'h50 + 32'(i)}, 1'b0, 1'b0);
        idle(5, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        check("t5_valid", out_valid, 1'b0);
        check("t5_ready", in_ready, 2'b11);
        got_d.delete(); got_v.delete();
        idle(4, 1'b1);
        check("t5_no_stale", got_d.size(), 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            logic [NV-1:0]    iv;
            logic [NV*FW-1:0] id;
            iv = NV'($urandom);
            id = {$urandom, $urandom};
            step(iv, id, ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
        end
        idle(12, 1'b1);
        check("end_drained", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
